div_qgen: RTL
=============

# div_qgen

Iterative radix-2 non-restoring mantissa divider that produces the quotient candidates and final remainder consumed by the divide rounder. It accepts two normalized significands and a precision select, then iterates one quotient digit per cycle. It pulses `done` with six aligned quotient candidates (q, q+ulp, q−ulp for both the [1,2) and [0,1) alignments) and a 128-bit signed remainder. It sits between the operand unpack stage and the rounder in the FP divide path.

## Interface
- No parameters; widths are fixed by the shared package.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `P` in 1: precision; 1 = single, 0 = double. Captured at start.
- `MantA` in 53: dividend significand {1, frac[51:0]}. SP uses [52:29] with [28:0] = 0.
- `MantB` in 53: divisor significand, same format as `MantA`.
- `busy` out 1: high from the cycle after start acceptance until `done`.
- `done` out 1: one-cycle pulse; outputs are valid from this cycle on.
- `q1`, `qp1`, `qm1` out 64: quotient, +ulp, −ulp; integer bit at [63].
- `q0`, `qp0`, `qm0` out 64: Q<<1 and its ±ulp; for Q in [0.5,1).
- `regr_out` out 128: corrected final remainder, sign-extended.

## Operation
- Reset values:
  - Every output is 0.
  - FSM is in IDLE.
- FSM states are IDLE → ITER → FIX → IDLE.
- IDLE with `start` high:
  - Load r = {3'b000, MantA} into a 56-bit signed register.
  - Latch B = MantB and P.
  - Clear the digit register and the counter.
- ITER, each cycle:
  - If r ≥ 0: d = +1 and r ← 2(r − B).
  - Otherwise: d = −1 and r ← 2(r + B).
  - Store digit bit p = (d == +1).
  - The count is N = 55 for DP and 26 for SP; move to FIX after N digits.
  - The first digit has weight 2^0.
- FIX, one cycle:
  - Q = p − ~p over N bits, placed so that weight 2^0 lands at bit 63; unused low bits are 0.
  - If the final (unshifted) r < 0: Q −= 2^−(N−1) and r += B.
  - Result is Q in [0.5,2) and r ≥ 0.
  - Relation: A = Q·B + r·2^−(N−1).
- Output formation:
  - q1 = Q.
  - q0 = {Q[62:0], 1'b0}.
  - ulp is at bit 11 for DP and bit 40 for SP.
  - qp1 = q1 + ulp; qm1 = q1 − ulp.
  - qp0 and qm0 are q0 ± ulp, all modulo 2^64.
- `regr_out` = sign-extend(r) to 128 bits, LSB at bit 0.
- Outputs hold their values until the next `done`.
- Boundary cases:
  - `start` while busy is ignored.
  - `reset` together with `start` leaves the block in IDLE with outputs at 0.
  - `reset` mid-ITER or mid-FIX aborts to IDLE, clears all outputs, and produces no `done`.
  - Operands with a hidden bit of 0 give undefined results; divide-by-zero is flagged upstream.

## Timing
- Start is accepted at cycle t.
- ITER runs during t+1 .. t+N.
- FIX runs at t+N+1.
- `done` is high at t+N+2, and `busy` falls that same cycle.
- Latency: DP = 57 cycles, SP = 28 cycles.
- A new `start` is accepted in the `done` cycle, since the FSM is already in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `DIV_EARLY_TERM_EN`.
- With the macro defined:
  - In ITER, if r − d·B is exactly 0, set the remaining digits to −1 equivalently, so that Q is exact.
  - The FSM jumps directly to FIX next cycle and r = 0.
  - Latency becomes k+2, where k is the number of digits taken.
- Without the macro: fixed latency N+2, and the zero-detect logic is not present.
- Q and r are identical either way.

## Structure
- Package `div_pkg` holds:
  - FSM state enum {IDLE, ITER, FIX}.
  - DP_ITERS = 55 and SP_ITERS = 26.
  - DP_ULP_BIT = 11 and SP_ULP_BIT = 40.
  - Remainder width 56.
- Sub-module `qcand`: combinational; takes Q and P and produces the six 64-bit candidates. It is registered in `div_qgen`.

## Test plan
- DP 1.0/1.0:
  - `done` at t+57.
  - q1 = 0x8000_0000_0000_0000, qp1 = 0x8000_0000_0000_0800, qm1 = 0x7FFF_FFFF_FFFF_F800.
  - q0 = 0; `regr_out` = 0.
- DP 1.5/1.0: q1 = 0xC000_0000_0000_0000, `regr_out` = 0, q1[63] = 1.
- DP 1.0/1.5:
  - q1 = 0x5555_5555_5555_5400 and q0 = 0xAAAA_AAAA_AAAA_A800.
  - `regr_out` nonzero with [127] = 0.
- SP 1.0/1.0 (P=1):
  - `done` at t+28.
  - qp1 = 0x8000_0100_0000_0000.
- Reset and handshake:
  - `reset` at t+20 of a DP op → no `done`, all outputs 0.
  - `start` pulsed during `busy` → ignored; exactly one `done`.
- With `DIV_EARLY_TERM_EN`: DP 1.0/1.0 → `done` at t+3 with the same q1 and `regr_out` as the first scenario.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 mantissa divider.
// Optional early termination is enabled with DIV_EARLY_TERM_EN.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int DP_ITERS   = 55;
   localparam int SP_ITERS   = 26;
   localparam int DP_ULP_BIT = 11;
   localparam int SP_ULP_BIT = 40;
   localparam int REM_W      = 56;

   function automatic logic [5:0] iters(input logic p);
      return p ? 6'(SP_ITERS) : 6'(DP_ITERS);
   endfunction

endpackage

// File: rtl/div_qgen_qcand.sv
// Quotient candidate generator: Q, Q<<1 and their +/- ulp variants.
// Purely combinational; the caller registers the results.
module qcand
   import div_pkg::*;
(
   input  logic [63:0] q,
   input  logic        p,
   output logic [63:0] q1,
   output logic [63:0] qp1,
   output logic [63:0] qm1,
   output logic [63:0] q0,
   output logic [63:0] qp0,
   output logic [63:0] qm0
);

   logic [63:0] ulp;

   assign ulp = p ? (64'd1 << SP_ULP_BIT)
                  : (64'd1 << DP_ULP_BIT);

   assign q1  = q;
   assign qp1 = q + ulp;
   assign qm1 = q - ulp;
   assign q0  = {q[62:0], 1'b0};
   assign qp0 = q0 + ulp;
   assign qm0 = q0 - ulp;

endmodule

// File: rtl/div_qgen.sv
// Non-restoring radix-2 divider producing rounder quotient candidates.
// DIV_EARLY_TERM_EN stops iterating once the partial remainder is zero.
module div_qgen
   import div_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         P,
   input  logic [52:0]  MantA,
   input  logic [52:0]  MantB,
   output logic         busy,
   output logic         done,
   output logic [63:0]  q1,
   output logic [63:0]  qp1,
   output logic [63:0]  qm1,
   output logic [63:0]  q0,
   output logic [63:0]  qp0,
   output logic [63:0]  qm0,
   output logic [127:0] regr_out
);

   state_t state, state_n;

   logic signed [REM_W-1:0] r;
   logic signed [REM_W-1:0] b_ext;
   logic signed [REM_W-1:0] r_diff;
   logic signed [REM_W-1:0] r_next;
   logic signed [REM_W-1:0] r_un;
   logic signed [REM_W-1:0] r_fix;

   logic [52:0] b;
   logic        prec;
   logic [54:0] pbits;
   logic [5:0]  cnt;
   logic [5:0]  n_iter;
   logic        d_pos;
   logic        last;
   logic        r_zero;
   logic        neg;

   logic [63:0] p_two;
   logic [63:0] mask;
   logic [63:0] q_raw;
   logic [63:0] corr;
   logic [63:0] q_fix;
   logic [5:0]  sh_q;
   logic [5:0]  sh_c;

   logic [63:0] c_q1, c_qp1, c_qm1;
   logic [63:0] c_q0, c_qp0, c_qm0;

   assign n_iter = iters(prec);
   assign b_ext  = $signed({3'b000, b});
   assign d_pos  = ~r[REM_W-1];
   assign r_diff = d_pos ? (r - b_ext)
                         : (r + b_ext);
   assign r_next = r_diff <<< 1;
   assign last   = (cnt == n_iter - 6'd1);

`ifdef DIV_EARLY_TERM_EN
   assign r_zero = (r_diff == '0);
`else
   assign r_zero = 1'b0;
`endif

   // Digits are +1/-1; value is 2P - (2^cnt - 1), MSB digit at bit 63.
   assign p_two = {8'd0, pbits, 1'b0};
   assign mask  = (64'd1 << cnt) - 64'd1;
   assign sh_q  = 6'(7'd64 - {1'b0, cnt});
   assign q_raw = (p_two - mask) << sh_q;
   assign sh_c  = 6'(7'd64 - {1'b0, n_iter});
   assign corr  = 64'd1 << sh_c;

   assign r_un  = r >>> 1;
   assign neg   = r_un[REM_W-1];
   assign r_fix = neg ? (r_un + b_ext) : r_un;
   assign q_fix = neg ? (q_raw - corr) : q_raw;

   qcand u_qcand (
      .q   (q_fix),
      .p   (prec),
      .q1  (c_q1),
      .qp1 (c_qp1),
      .qm1 (c_qm1),
      .q0  (c_q0),
      .qp0 (c_qp0),
      .qm0 (c_qm0)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = ITER;
         ITER:    if (last || r_zero) state_n = FIX;
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r        <= '0;
         b        <= '0;
         prec     <= 1'b0;
         pbits    <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         q1       <= '0;
         qp1      <= '0;
         qm1      <= '0;
         q0       <= '0;
         qp0      <= '0;
         qm0      <= '0;
         regr_out <= '0;
      end else begin
         done <= 1'b0;
         busy <= (state_n != IDLE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  r     <= $signed({3'b000, MantA});
                  b     <= MantB;
                  prec  <= P;
                  pbits <= '0;
                  cnt   <= '0;
               end
            end
            ITER: begin
               r     <= r_zero ? '0 : r_next;
               pbits <= {pbits[53:0], d_pos};
               cnt   <= cnt + 6'd1;
            end
            FIX: begin
               q1       <= c_q1;
               qp1      <= c_qp1;
               qm1      <= c_qm1;
               q0       <= c_q0;
               qp0      <= c_qp0;
               qm0      <= c_qm0;
               regr_out <= {{72{r_fix[REM_W-1]}}, r_fix};
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
